// File: rtl/issue_sched_if.sv
// Shared payload types and the RS/FU-side bundle of the issue scheduler.
//   master : RS/FU/ROB side (drives candidates, wb_resp, ordered_ok)
//   slave  : issue_sched (drives rs_instr_req, FU issue registers, credit state)
package issue_sched_pkg;

  // Instruction handed from a reservation station to a functional unit.
  typedef struct packed {
    logic        valid;
    logic [5:0]  rob_tag;
    logic [7:0]  opcode;
    logic [16:0] imm;
  } ooo_instr_t;

  // Decoded control word travelling alongside the instruction.
  typedef struct packed {
    logic [3:0] fu_op;
    logic [1:0] size;
    logic       sign_ext;
    logic [8:0] rsvd;
  } ctrl_word_t;

endpackage

interface issue_sched_if #(
  parameter int unsigned NUM_CH = 5,
  parameter int unsigned CNT_W  = 3
);

  logic [NUM_CH-1:0]                        ordered_ok;
  logic [NUM_CH-1:0]                        rs_instr_req;
  issue_sched_pkg::ooo_instr_t [NUM_CH-1:0] rs_instr_struct;
  issue_sched_pkg::ctrl_word_t [NUM_CH-1:0] rs_ctrl_word;
  logic [NUM_CH-1:0]                        wb_resp;
  issue_sched_pkg::ooo_instr_t [NUM_CH-1:0] fu_instr_struct;
  issue_sched_pkg::ctrl_word_t [NUM_CH-1:0] fu_ctrl_word;
  logic [NUM_CH-1:0][CNT_W-1:0]             credits;
  logic [NUM_CH-1:0]                        credit_err;

  modport master (
    output ordered_ok, rs_instr_struct, rs_ctrl_word, wb_resp,
    input  rs_instr_req, fu_instr_struct, fu_ctrl_word, credits, credit_err
  );

  modport slave (
    input  ordered_ok, rs_instr_struct, rs_ctrl_word, wb_resp,
    output rs_instr_req, fu_instr_struct, fu_ctrl_word, credits, credit_err
  );

endinterface

// File: rtl/issue_sched.sv
// Credit-gated, registered issue scheduler between reservation stations and
// functional units. Each channel is independent.
//   clk, rst : core clock, synchronous active-high reset
//   flush    : pipeline flush; clears issue registers and reloads credits
//   bus      : issue_sched_if.slave (RS request/candidate, FU issue register,
//              wb_resp credit return, ordering permit, credit state/errors)
module issue_sched
  import issue_sched_pkg::*;
#(
  parameter  int unsigned                      NUM_CH       = 5,
  parameter  int unsigned                      MAX_CREDITS  = 4,
  localparam int unsigned                      CNT_W        = $clog2(MAX_CREDITS + 1),
  parameter  logic [NUM_CH-1:0][CNT_W-1:0]     CH_CREDITS   = {NUM_CH{CNT_W'(1)}},
  parameter  logic [NUM_CH-1:0]                ORDERED_MASK = 5'b01000,
  parameter  logic [NUM_CH-1:0]                WB_BYPASS    = 5'b10001
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  issue_sched_if.slave bus
);

  logic [NUM_CH-1:0]             avail;
  logic [NUM_CH-1:0]             gate;
  logic [NUM_CH-1:0]             req;
  logic [NUM_CH-1:0]             issue;
  logic [NUM_CH-1:0][CNT_W-1:0]  credits_q;
  logic [NUM_CH-1:0][CNT_W-1:0]  credits_d;
  logic [NUM_CH-1:0]             err_q;
  logic [NUM_CH-1:0]             err_d;
  ooo_instr_t [NUM_CH-1:0]       fu_instr_q;
  ooo_instr_t [NUM_CH-1:0]       fu_instr_d;
  ctrl_word_t [NUM_CH-1:0]       fu_ctrl_q;
  ctrl_word_t [NUM_CH-1:0]       fu_ctrl_d;

  // Per-channel request, issue decision and next credit/error state.
  always_comb begin
    avail      = '0;
    gate       = '0;
    req        = '0;
    issue      = '0;
    credits_d  = credits_q;
    err_d      = err_q;
    fu_instr_d = '0;
    fu_ctrl_d  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      // A same-cycle return can stand in for an empty counter on bypass channels.
      avail[c] = (credits_q[c] != '0) | (WB_BYPASS[c] & bus.wb_resp[c]);
      gate[c]  = ~ORDERED_MASK[c] | bus.ordered_ok[c];
      req[c]   = avail[c] & gate[c] & ~flush;
      issue[c] = req[c] & bus.rs_instr_struct[c].valid;
      if (issue[c]) begin
        fu_instr_d[c] = bus.rs_instr_struct[c];
        fu_ctrl_d[c]  = bus.rs_ctrl_word[c];
      end
      // Issue without return needs a nonzero counter, so this cannot underflow.
      if (issue[c] && !bus.wb_resp[c]) begin
        credits_d[c] = credits_q[c] - CNT_W'(1);
      end else if (!issue[c] && bus.wb_resp[c]) begin
        if (credits_q[c] == CH_CREDITS[c]) begin
          err_d[c] = 1'b1;
        end else begin
          credits_d[c] = credits_q[c] + CNT_W'(1);
        end
      end
    end
  end

  // State registers; reset beats flush, flush beats issue and credit return.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits_q  <= CH_CREDITS;
      err_q      <= '0;
      fu_instr_q <= '0;
      fu_ctrl_q  <= '0;
    end else if (flush) begin
      credits_q  <= CH_CREDITS;
      fu_instr_q <= '0;
      fu_ctrl_q  <= '0;
    end else begin
      credits_q  <= credits_d;
      err_q      <= err_d;
      fu_instr_q <= fu_instr_d;
      fu_ctrl_q  <= fu_ctrl_d;
    end
  end

  assign bus.rs_instr_req    = req;
  assign bus.fu_instr_struct = fu_instr_q;
  assign bus.fu_ctrl_word    = fu_ctrl_q;
  assign bus.credits         = credits_q;
  assign bus.credit_err      = err_q;

endmodule

// File: tb/tb_issue_sched.sv
// Self-checking bench for issue_sched: directed scenarios plus a randomized
// run compared against an in-flight-count model of each channel.
module tb_issue_sched;
  import issue_sched_pkg::*;

  localparam int unsigned NUM_CH      = 5;
  localparam int unsigned MAX_CREDITS = 4;
  localparam int unsigned CNT_W       = $clog2(MAX_CREDITS + 1);
  // alu=1, mul=3, div=1, mem=1, br=2
  localparam logic [NUM_CH-1:0][CNT_W-1:0] CH_CREDITS = {3'd2, 3'd1, 3'd1, 3'd3, 3'd1};
  localparam logic [NUM_CH-1:0] ORDERED_MASK = 5'b01000;
  localparam logic [NUM_CH-1:0] WB_BYPASS    = 5'b10001;

  logic clk;
  logic rst;
  logic flush;

  issue_sched_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  issue_sched #(
    .NUM_CH      (NUM_CH),
    .MAX_CREDITS (MAX_CREDITS),
    .CH_CREDITS  (CH_CREDITS),
    .ORDERED_MASK(ORDERED_MASK),
    .WB_BYPASS   (WB_BYPASS)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: each channel is an FU with fixed capacity and a count of
  // instructions currently inside it.
  int         cap [NUM_CH] = '{1, 3, 1, 1, 2};
  bit         byp [NUM_CH] = '{1, 0, 0, 0, 1};
  bit         ord [NUM_CH] = '{0, 0, 0, 1, 0};
  int         inflight [NUM_CH];
  bit         m_err [NUM_CH];
  ooo_instr_t m_fu [NUM_CH];
  ctrl_word_t m_cw [NUM_CH];

  function automatic logic [NUM_CH-1:0] exp_req();
    logic [NUM_CH-1:0] r;
    for (int c = 0; c < NUM_CH; c++) begin
      bit room    = (inflight[c] < cap[c]) || (byp[c] && bus.wb_resp[c]);
      bit allowed = !ord[c] || bus.ordered_ok[c];
      r[c] = room && allowed && !flush;
    end
    return r;
  endfunction

  function automatic logic [NUM_CH-1:0][CNT_W-1:0] exp_credits();
    logic [NUM_CH-1:0][CNT_W-1:0] v;
    for (int c = 0; c < NUM_CH; c++) v[c] = CNT_W'(cap[c] - inflight[c]);
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_err();
    logic [NUM_CH-1:0] v;
    for (int c = 0; c < NUM_CH; c++) v[c] = m_err[c];
    return v;
  endfunction

  function automatic ooo_instr_t [NUM_CH-1:0] exp_fu();
    ooo_instr_t [NUM_CH-1:0] v;
    for (int c = 0; c < NUM_CH; c++) v[c] = m_fu[c];
    return v;
  endfunction

  function automatic ctrl_word_t [NUM_CH-1:0] exp_cw();
    ctrl_word_t [NUM_CH-1:0] v;
    for (int c = 0; c < NUM_CH; c++) v[c] = m_cw[c];
    return v;
  endfunction

  function automatic ooo_instr_t rand_instr(bit v);
    ooo_instr_t r;
    r = ooo_instr_t'(32'($urandom));
    r.valid = v;
    return r;
  endfunction

  task automatic clear_inputs();
    flush               = 1'b0;
    bus.ordered_ok      = '0;
    bus.wb_resp         = '0;
    bus.rs_instr_struct = '0;
    bus.rs_ctrl_word    = '0;
  endtask

  // Advance one clock: model decides issues from pre-edge inputs, then both step.
  task automatic tick();
    logic [NUM_CH-1:0] r;
    bit                iss [NUM_CH];
    bit                ret [NUM_CH];
    bit                r_rst, r_flush;
    ooo_instr_t        ins [NUM_CH];
    ctrl_word_t        cw  [NUM_CH];
    r = exp_req();
    r_rst = rst;
    r_flush = flush;
    for (int c = 0; c < NUM_CH; c++) begin
      ins[c] = bus.rs_instr_struct[c];
      cw[c]  = bus.rs_ctrl_word[c];
      iss[c] = r[c] && ins[c].valid;
      ret[c] = bus.wb_resp[c];
    end
    @(posedge clk);
    for (int c = 0; c < NUM_CH; c++) begin
      if (r_rst) begin
        inflight[c] = 0; m_err[c] = 0; m_fu[c] = '0; m_cw[c] = '0;
      end else if (r_flush) begin
        inflight[c] = 0; m_fu[c] = '0; m_cw[c] = '0;
      end else begin
        m_fu[c] = iss[c] ? ins[c] : '0;
        m_cw[c] = iss[c] ? cw[c]  : '0;
        if (ret[c] && !iss[c] && inflight[c] == 0) m_err[c] = 1;
        inflight[c] = inflight[c] + int'(iss[c]) - int'(ret[c]);
        if (inflight[c] < 0) inflight[c] = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.rs_instr_req !== 5'b10111) begin
      errors++; $display("FAIL reset_req: got %b expected %b", bus.rs_instr_req, 5'b10111);
    end
    rst = 1'b0;
    checks++;
    if (bus.credits !== CH_CREDITS) begin
      errors++; $display("FAIL reset_credits: got %h expected %h", bus.credits, CH_CREDITS);
    end
    checks++;
    if (bus.fu_instr_struct !== '0 || bus.fu_ctrl_word !== '0) begin
      errors++; $display("FAIL reset_fu: got %h/%h expected 0", bus.fu_instr_struct, bus.fu_ctrl_word);
    end
    checks++;
    if (bus.credit_err !== '0) begin
      errors++; $display("FAIL reset_err: got %b expected 0", bus.credit_err);
    end
  endtask

  task automatic test_alu_bypass();
    bit prev = 0;
    ooo_instr_t sent;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      sent = rand_instr(1);
      bus.rs_instr_struct[0] = sent;
      bus.rs_ctrl_word[0]    = ctrl_word_t'(16'($urandom));
      bus.wb_resp[0]         = prev;
      #1;
      checks++;
      if (bus.rs_instr_req[0] !== 1'b1) begin
        errors++; $display("FAIL alu_req k=%0d: got %b expected 1", k, bus.rs_instr_req[0]);
      end
      tick();
      checks++;
      if (bus.fu_instr_struct[0] !== sent || bus.credits[0] !== CNT_W'(0)) begin
        errors++; $display("FAIL alu_issue k=%0d: got %h cr=%0d expected %h cr=0",
                           k, bus.fu_instr_struct[0], bus.credits[0], sent);
      end
      prev = 1;
    end
    bus.rs_instr_struct[0] = '0;
    bus.wb_resp[0] = 1'b1;
    tick();
    bus.wb_resp[0] = 1'b0;
    checks++;
    if (bus.credits[0] !== CNT_W'(1) || bus.fu_instr_struct[0] !== '0) begin
      errors++; $display("FAIL alu_drain: got cr=%0d fu=%h expected cr=1 fu=0",
                         bus.credits[0], bus.fu_instr_struct[0]);
    end
  endtask

  task automatic test_mul_credits();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      bus.rs_instr_struct[1] = rand_instr(1);
      #1;
      checks++;
      if (bus.rs_instr_req[1] !== (k < 3)) begin
        errors++; $display("FAIL mul_req k=%0d: got %b expected %b", k, bus.rs_instr_req[1], k < 3);
      end
      tick();
      checks++;
      if (bus.credits[1] !== exp_credits()[1]) begin
        errors++; $display("FAIL mul_credits k=%0d: got %0d expected %0d", k, bus.credits[1], exp_credits()[1]);
      end
    end
    bus.wb_resp[1] = 1'b1;
    tick();
    bus.wb_resp[1] = 1'b0;
    #1;
    checks++;
    if (bus.credits[1] !== CNT_W'(1) || bus.rs_instr_req[1] !== 1'b1) begin
      errors++; $display("FAIL mul_return: got cr=%0d req=%b expected cr=1 req=1",
                         bus.credits[1], bus.rs_instr_req[1]);
    end
    bus.rs_instr_struct[1] = '0;
  endtask

  task automatic test_mem_ordering();
    ooo_instr_t sent;
    do_reset();
    sent = rand_instr(1);
    bus.rs_instr_struct[3] = sent;
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++;
      if (bus.rs_instr_req[3] !== 1'b0) begin
        errors++; $display("FAIL mem_blocked_req k=%0d: got %b expected 0", k, bus.rs_instr_req[3]);
      end
      tick();
      checks++;
      if (bus.fu_instr_struct[3] !== '0) begin
        errors++; $display("FAIL mem_blocked_fu k=%0d: got %h expected 0", k, bus.fu_instr_struct[3]);
      end
    end
    bus.ordered_ok[3] = 1'b1;
    #1;
    checks++;
    if (bus.rs_instr_req[3] !== 1'b1) begin
      errors++; $display("FAIL mem_permit_req: got %b expected 1", bus.rs_instr_req[3]);
    end
    tick();
    checks++;
    if (bus.fu_instr_struct[3] !== sent) begin
      errors++; $display("FAIL mem_permit_fu: got %h expected %h", bus.fu_instr_struct[3], sent);
    end
    clear_inputs();
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      bus.rs_instr_struct[1] = rand_instr(1);
      bus.rs_instr_struct[4] = rand_instr(1);
      tick();
    end
    checks++;
    if (bus.credits[1] !== CNT_W'(0) || bus.fu_instr_struct[1].valid !== 1'b1) begin
      errors++; $display("FAIL flush_setup: got cr=%0d v=%b expected cr=0 v=1",
                         bus.credits[1], bus.fu_instr_struct[1].valid);
    end
    flush = 1'b1;
    bus.wb_resp = '1;
    bus.ordered_ok = '1;
    for (int c = 0; c < NUM_CH; c++) bus.rs_instr_struct[c] = rand_instr(1);
    #1;
    checks++;
    if (bus.rs_instr_req !== '0) begin
      errors++; $display("FAIL flush_req: got %b expected 0", bus.rs_instr_req);
    end
    tick();
    clear_inputs();
    checks++;
    if (bus.fu_instr_struct !== '0 || bus.fu_ctrl_word !== '0) begin
      errors++; $display("FAIL flush_fu: got %h/%h expected 0", bus.fu_instr_struct, bus.fu_ctrl_word);
    end
    checks++;
    if (bus.credits !== CH_CREDITS || bus.credit_err !== '0) begin
      errors++; $display("FAIL flush_state: got cr=%h err=%b expected cr=%h err=0",
                         bus.credits, bus.credit_err, CH_CREDITS);
    end
  endtask

  task automatic test_div_credit_err();
    do_reset();
    bus.wb_resp[2] = 1'b1;
    tick();
    bus.wb_resp[2] = 1'b0;
    checks++;
    if (bus.credits[2] !== CNT_W'(1) || bus.credit_err !== 5'b00100) begin
      errors++; $display("FAIL div_err_set: got cr=%0d err=%b expected cr=1 err=00100",
                         bus.credits[2], bus.credit_err);
    end
    for (int k = 0; k < 3; k++) begin
      flush = (k == 1);
      tick();
      checks++;
      if (bus.credit_err[2] !== 1'b1) begin
        errors++; $display("FAIL div_err_sticky k=%0d: got %b expected 1", k, bus.credit_err[2]);
      end
    end
    flush = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.credit_err !== '0) begin
      errors++; $display("FAIL div_err_clear: got %b expected 0", bus.credit_err);
    end
  endtask

  task automatic test_back_to_back_full();
    ooo_instr_t sent;
    do_reset();
    sent = rand_instr(1);
    bus.rs_instr_struct[4] = sent;
    bus.wb_resp[4] = 1'b1;
    tick();
    clear_inputs();
    checks++;
    if (bus.credits[4] !== CNT_W'(2) || bus.fu_instr_struct[4] !== sent || bus.credit_err[4] !== 1'b0) begin
      errors++; $display("FAIL full_issue_ret: got cr=%0d fu=%h err=%b expected cr=2 fu=%h err=0",
                         bus.credits[4], bus.fu_instr_struct[4], bus.credit_err[4], sent);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(63) == 0);
      flush = ($urandom_range(11) == 0);
      for (int c = 0; c < NUM_CH; c++) begin
        bus.rs_instr_struct[c] = rand_instr(1'($urandom_range(1)));
        bus.rs_ctrl_word[c]    = ctrl_word_t'(16'($urandom));
        bus.wb_resp[c]         = ($urandom_range(2) == 0);
        bus.ordered_ok[c]      = 1'($urandom_range(1));
      end
      #1;
      checks++;
      if (bus.rs_instr_req !== exp_req()) begin
        errors++; $display("FAIL rand_req n=%0d: got %b expected %b", n, bus.rs_instr_req, exp_req());
      end
      tick();
      checks++;
      if (bus.credits !== exp_credits() || bus.credit_err !== exp_err()) begin
        errors++; $display("FAIL rand_state n=%0d: got cr=%h err=%b expected cr=%h err=%b",
                           n, bus.credits, bus.credit_err, exp_credits(), exp_err());
      end
      checks++;
      if (bus.fu_instr_struct !== exp_fu() || bus.fu_ctrl_word !== exp_cw()) begin
        errors++; $display("FAIL rand_fu n=%0d: got %h/%h expected %h/%h",
                           n, bus.fu_instr_struct, bus.fu_ctrl_word, exp_fu(), exp_cw());
      end
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_alu_bypass();
    test_mul_credits();
    test_mem_ordering();
    test_flush();
    test_div_credit_err();
    test_back_to_back_full();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
